// File: rtl/load_store_unit.sv
// Data-memory initiator for the RV32 core: accepts one load/store at a time
// from execute, issues it on a req/gnt + rvalid memory port, and returns
// extended load data (or an error) to writeback over valid/ready.
//
// Ports:
//   clk, rst                      clock, synchronous active-low reset
//   req_valid_i/req_ready_o       execute request handshake
//   req_we_i, req_funct3_i        store flag and RV32 funct3
//   req_addr_i, req_wdata_i       byte address and unshifted store data
//   req_rd_i                      destination tag, passed through
//   mem_req_o/mem_gnt_i           memory request handshake
//   mem_we_o, mem_be_o            write enable and byte enables
//   mem_addr_o, mem_wdata_o       word-aligned address, lane-aligned data
//   mem_rvalid_i, mem_rdata_i     read data return
//   resp_valid_o/resp_ready_i     writeback handshake
//   resp_data_o, resp_rd_o        extended load data and rd tag
//   resp_err_o                    misaligned access or illegal funct3
module load_store_unit #(
    parameter int unsigned AWIDTH = 32,
    parameter int unsigned DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [AWIDTH-1:0] req_addr_i,
    input  logic [DWIDTH-1:0] req_wdata_i,
    input  logic [4:0]        req_rd_i,
    output logic              mem_req_o,
    input  logic              mem_gnt_i,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0] mem_wdata_o,
    input  logic              mem_rvalid_i,
    input  logic [DWIDTH-1:0] mem_rdata_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [DWIDTH-1:0] resp_data_o,
    output logic [4:0]        resp_rd_o,
    output logic              resp_err_o
);

    localparam int unsigned BE_W  = 4;
    localparam int unsigned F3_W  = 3;
    localparam int unsigned OFF_W = 2;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t state_q, state_d;

    // Captured request attributes needed after the accept cycle
    logic             we_q, we_d;
    logic [F3_W-1:0]  funct3_q, funct3_d;
    logic [OFF_W-1:0] off_q, off_d;

    // Next values of the registered outputs
    logic              mem_req_d, mem_we_d, resp_valid_d, resp_err_d;
    logic [BE_W-1:0]   mem_be_d;
    logic [AWIDTH-1:0] mem_addr_d;
    logic [DWIDTH-1:0] mem_wdata_d, resp_data_d;
    logic [4:0]        resp_rd_d;

    // Request decode
    logic              accept_c, legal_c;
    logic [OFF_W-1:0]  off_c;
    logic [BE_W-1:0]   be_c;
    logic [DWIDTH-1:0] wdata_c;
    logic [DWIDTH-1:0] shifted_c, load_c;

    assign req_ready_o = (state_q == IDLE) && rst;
    assign accept_c    = req_valid_i && req_ready_o;

    // Byte enables, lane shift and legality of the incoming request
    always_comb begin
        off_c   = req_addr_i[1:0];
        be_c    = '0;
        legal_c = 1'b0;
        wdata_c = req_wdata_i << {off_c, 3'b000};
        case (req_funct3_i[1:0])
            2'b00:   be_c = BE_W'(4'b0001 << off_c);
            2'b01:   be_c = BE_W'(4'b0011 << off_c);
            2'b10:   be_c = 4'b1111;
            default: be_c = '0;
        endcase
        case (req_funct3_i)
            3'b000:  legal_c = 1'b1;
            3'b001:  legal_c = !off_c[0];
            3'b010:  legal_c = (off_c == 2'b00);
            3'b100:  legal_c = !req_we_i;
            3'b101:  legal_c = !req_we_i && !off_c[0];
            default: legal_c = 1'b0;
        endcase
    end

    // Lane extraction and extension of the returned read word
    always_comb begin
        shifted_c = mem_rdata_i >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  load_c = {{(DWIDTH-8){shifted_c[7]}}, shifted_c[7:0]};
            3'b001:  load_c = {{(DWIDTH-16){shifted_c[15]}}, shifted_c[15:0]};
            3'b010:  load_c = shifted_c;
            3'b100:  load_c = {{(DWIDTH-8){1'b0}}, shifted_c[7:0]};
            3'b101:  load_c = {{(DWIDTH-16){1'b0}}, shifted_c[15:0]};
            default: load_c = '0;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            funct3_q     <= '0;
            off_q        <= '0;
            mem_req_o    <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_be_o     <= '0;
            mem_addr_o   <= '0;
            mem_wdata_o  <= '0;
            resp_valid_o <= 1'b0;
            resp_data_o  <= '0;
            resp_rd_o    <= '0;
            resp_err_o   <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            funct3_q     <= funct3_d;
            off_q        <= off_d;
            mem_req_o    <= mem_req_d;
            mem_we_o     <= mem_we_d;
            mem_be_o     <= mem_be_d;
            mem_addr_o   <= mem_addr_d;
            mem_wdata_o  <= mem_wdata_d;
            resp_valid_o <= resp_valid_d;
            resp_data_o  <= resp_data_d;
            resp_rd_o    <= resp_rd_d;
            resp_err_o   <= resp_err_d;
        end
    end

    // Next-state logic; rvalid is only looked at in WAIT
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_c) state_d = legal_c ? ISSUE : RESP;
            ISSUE:   if (mem_gnt_i) state_d = we_q ? RESP : WAIT;
            WAIT:    if (mem_rvalid_i) state_d = RESP;
            RESP:    if (resp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output next values; everything holds unless a transition updates it
    always_comb begin
        we_d         = we_q;
        funct3_d     = funct3_q;
        off_d        = off_q;
        mem_we_d     = mem_we_o;
        mem_be_d     = mem_be_o;
        mem_addr_d   = mem_addr_o;
        mem_wdata_d  = mem_wdata_o;
        resp_data_d  = resp_data_o;
        resp_rd_d    = resp_rd_o;
        resp_err_d   = resp_err_o;
        mem_req_d    = (state_d == ISSUE);
        resp_valid_d = (state_d == RESP);
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    we_d      = req_we_i;
                    funct3_d  = req_funct3_i;
                    off_d     = off_c;
                    resp_rd_d = req_rd_i;
                    if (legal_c) begin
                        mem_we_d    = req_we_i;
                        mem_be_d    = be_c;
                        mem_addr_d  = {req_addr_i[AWIDTH-1:2], 2'b00};
                        mem_wdata_d = wdata_c;
                    end else begin
                        resp_data_d = '0;
                        resp_err_d  = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (mem_gnt_i && we_q) begin
                    resp_data_d = '0;
                    resp_err_d  = 1'b0;
                end
            end
            WAIT: begin
                if (mem_rvalid_i) begin
                    resp_data_d = load_c;
                    resp_err_d  = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Data-memory initiator for the RV32 core. It is the write/read-issuing end of the memory port; the memory block is the responder.
- Accepts one load/store request per transaction from execute, using ALU result as address and rs2 data as store data.
- Drives a request/grant + rvalid data-memory interface with word-aligned address, byte enables and lane-shifted store data.
- Returns sign/zero-extended load data, or an error, to writeback over a valid/ready handshake.
- One transaction outstanding at a time.

Parameters:
AWIDTH, 32, address width
DWIDTH, 32, data width; byte-lane logic is defined for 32 only

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-low reset (rst==0 resets on clk edge)
req_valid_i  in  1  execute presents a request
req_ready_o  out  1  LSU can accept a request
req_we_i  in  1  1=store, 0=load
req_funct3_i  in  3  RV32 funct3 of load/store
req_addr_i  in  AWIDTH  byte address (ALU result)
req_wdata_i  in  DWIDTH  store data (rs2), unshifted
req_rd_i  in  5  destination register tag, passed through
mem_req_o  out  1  request to data memory
mem_gnt_i  in  1  memory accepts request this cycle
mem_we_o  out  1  write enable
mem_be_o  out  4  byte enables
mem_addr_o  out  AWIDTH  word-aligned address, bits[1:0]=00
mem_wdata_o  out  DWIDTH  lane-aligned store data
mem_rvalid_i  in  1  read data valid
mem_rdata_i  in  DWIDTH  read word
resp_valid_o  out  1  response available
resp_ready_i  in  1  writeback consumes response
resp_data_o  out  DWIDTH  extended load data; 0 for stores and errors
resp_rd_o  out  5  captured rd
resp_err_o  out  1  misaligned access or illegal funct3

Behaviour:
- Reset:
  - State goes to IDLE.
  - All registered outputs clear: mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, resp_valid_o, resp_data_o, resp_rd_o, resp_err_o = 0.
  - req_ready_o = (state==IDLE) && rst, so it is 0 while rst is low.
- Reset mid-transaction: the transaction is abandoned, with no response and no retry. A later mem_rvalid_i is ignored because rvalid is sampled only in WAIT.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready_o = 1.
  - On req_valid_i && req_ready_o, capture we, funct3, addr[1:0], rd.
  - Compute be, shifted wdata and aligned addr in the same cycle.
  - If the request is illegal → RESP with err=1, data=0, and no memory access.
  - Otherwise → ISSUE.
- ISSUE:
  - mem_req_o = 1; addr, we, be and wdata are held stable until mem_gnt_i.
  - On grant: a store goes to RESP; a load goes to WAIT.
  - mem_req_o drops the cycle after grant.
- WAIT:
  - Hold until mem_rvalid_i.
  - Then capture the extended data and go to RESP.
  - rvalid coincident with grant in ISSUE is a protocol violation and is ignored.
- RESP:
  - resp_valid_o = 1; data, rd and err are held stable until resp_ready_i.
  - On resp_ready_i → IDLE.
  - No new request is accepted in the same cycle; req_ready_o rises the next cycle.
- Minimum latency (accept = cycle 0, zero-wait memory):
  - Store: resp_valid_o at cycle 2.
  - Load: resp_valid_o at cycle 3.
  - Back-to-back throughput is one transaction per 3 cycles (store) or 4 cycles (load).
- funct3 legality:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Anything else → err.
- Misalignment → err:
  - Halfword with addr[0]=1.
  - Word with addr[1:0]≠00.
- Byte enables:
  - Byte: 0001<<off.
  - Half: 0011<<off.
  - Word: 1111.
  - off = addr[1:0].
- mem_wdata_o = req_wdata_i << (8*off). Unused lanes carry the shifted value's zeros.
- Load extraction:
  - Compute s = mem_rdata_i >> (8*off).
  - LB/LH sign-extend bit 7 or 15 of s.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- Stores: resp_data_o = 0, err = 0. The response still flows so writeback sees completion.
- mem_addr_o = {addr[AWIDTH-1:2], 2'b00}.

Test Plan:
- SW addr=0x100, data=0xDEADBEEF, gnt on first ISSUE cycle → mem_addr_o=0x100, be=1111, wdata=0xDEADBEEF; resp_valid_o at cycle 2, data=0, err=0.
- SB addr=0x103, data=0x000000A5 → be=1000, wdata=0xA5000000; LBU from 0x103 with rdata=0xA5000000 → resp_data_o=0x000000A5; LB from 0x103 → 0xFFFFFFA5.
- LH addr=0x102, rdata=0x80010000, rvalid 3 cycles after grant, resp_ready_i low 2 cycles → resp_data_o=0xFFFF8001 held stable for all 3 valid cycles; rd passed through.
- LW addr=0x101 → no mem_req_o, resp_err_o=1, resp_data_o=0; LH addr=0x201 → err; load funct3=011 → err.
- mem_gnt_i withheld 4 cycles → mem_req_o, addr, be, wdata constant across all 5 ISSUE cycles; req_ready_o=0 throughout.
- Reset (rst=0) asserted in WAIT, then a stale mem_rvalid_i=1 one cycle after release → all outputs 0, no resp_valid_o, req_ready_o=1 on the first cycle after release.
